// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared types and helpers for the calculator square-root sequencer
package calc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } sqrt_state_t;

  function automatic int sqrt_root_w(input int in_w);
    return (in_w + 1) / 2;
  endfunction

  // A transfer completes on any edge where the producer's valid meets the consumer's ready.
  function automatic logic hs_fire(input logic valid, input logic ready);
    return valid && ready;
  endfunction

endpackage

// File: rtl/sqrt_seq_ctrl_if.sv
// rtl/sqrt_seq_ctrl_if.sv - operand/result handshake bundle for the square-root sequencer
interface sqrt_seq_ctrl_if #(parameter int IN_W = 10);
  import calc_pkg::*;

  localparam int ROOT_W = sqrt_root_w(IN_W);

  logic              in_valid;
  logic              in_ready;
  logic [IN_W-1:0]   num;
  logic              out_valid;
  logic              out_ready;
  logic [ROOT_W-1:0] root;
  logic [ROOT_W:0]   rem;
  logic              busy;

  modport slave (
    input  in_valid, num, out_ready,
    output in_ready, out_valid, root, rem, busy
  );

  modport master (
    output in_valid, num, out_ready,
    input  in_ready, out_valid, root, rem, busy
  );

endinterface

// File: rtl/sqrt_step.sv
// rtl/sqrt_step.sv - one restoring digit-by-digit square-root iteration
module sqrt_step #(
  parameter int ROOT_W = 5
) (
  input  logic [ROOT_W+1:0] rem_acc,
  input  logic [ROOT_W-1:0] root,
  input  logic [1:0]        pair,
  output logic [ROOT_W+1:0] rem_acc_nxt,
  output logic [ROOT_W-1:0] root_nxt
);

  localparam int SH_W = ROOT_W + 2;

  logic [SH_W-1:0] rem_sh;
  logic [SH_W-1:0] trial;
  logic [SH_W:0]   diff;
  logic            borrow;

  // The partial remainder never exceeds twice the partial root, so the shifted value fits SH_W bits.
  assign rem_sh = SH_W'({rem_acc, pair});
  assign trial  = {root, 2'b01};
  assign diff   = {1'b0, rem_sh} - {1'b0, trial};
  assign borrow = diff[SH_W];

  assign rem_acc_nxt = borrow ? rem_sh : diff[SH_W-1:0];
  assign root_nxt    = ROOT_W'({root, ~borrow});

endmodule

// File: rtl/sqrt_seq_ctrl.sv
// rtl/sqrt_seq_ctrl.sv - multi-cycle integer square root with remainder, one root bit per clock
module sqrt_seq_ctrl
  import calc_pkg::*;
#(
  parameter int IN_W = 10
) (
  input  logic            clk,
  input  logic            rst,
  sqrt_seq_ctrl_if.slave  bus
);

  localparam int ROOT_W = sqrt_root_w(IN_W);
  localparam int OP_W   = 2 * ROOT_W;
  localparam int CNT_W  = (ROOT_W > 1) ? $clog2(ROOT_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROOT_W - 1);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_CALC = CALC;
  localparam logic [1:0] ST_DONE = DONE;

  logic [1:0]        state;
  logic [OP_W-1:0]   op;
  logic [ROOT_W+1:0] rem_acc;
  logic [ROOT_W-1:0] root_q;
  logic [CNT_W-1:0]  cnt;
  logic [ROOT_W+1:0] rem_acc_nxt;
  logic [ROOT_W-1:0] root_nxt;

  sqrt_step #(.ROOT_W(ROOT_W)) u_step (
    .rem_acc     (rem_acc),
    .root        (root_q),
    .pair        (op[OP_W-1 -: 2]),
    .rem_acc_nxt (rem_acc_nxt),
    .root_nxt    (root_nxt)
  );

  assign bus.in_ready  = (state == ST_IDLE);
  assign bus.out_valid = (state == ST_DONE);
  assign bus.busy      = (state != ST_IDLE);
  assign bus.root      = root_q;
  assign bus.rem       = rem_acc[ROOT_W:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      op      <= '0;
      rem_acc <= '0;
      root_q  <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (hs_fire(bus.in_valid, bus.in_ready)) begin
            op      <= OP_W'(bus.num);
            rem_acc <= '0;
            root_q  <= '0;
            cnt     <= '0;
            state   <= ST_CALC;
          end
        end
        ST_CALC: begin
          op      <= op << 2;
          rem_acc <= rem_acc_nxt;
          root_q  <= root_nxt;
          cnt     <= cnt + 1'b1;
          if (cnt == CNT_LAST) state <= ST_DONE;
        end
        ST_DONE: begin
          // New operands wait for the cycle after the result leaves.
          if (hs_fire(bus.out_valid, bus.out_ready)) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
